// File: rtl/instr_test_monitor_pkg.sv
// Shared types for the instruction-test self-check monitor: FSM states,
// end-of-run modes and the failure record carried on the log stream.
package instr_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int END_FIXED = 0;
    localparam int END_HALT  = 1;

    // Record fields are sized for the widest supported configuration; the
    // monitor fills the low bits and zeroes the rest.
    localparam int REC_IDX_W  = 16;
    localparam int REC_DATA_W = 64;

    typedef struct packed {
        logic [REC_IDX_W-1:0]  index;
        logic [REC_DATA_W-1:0] expected;
        logic [REC_DATA_W-1:0] actual;
    } fail_rec_t;

    // An entry fails when any compared bit differs; a zero mask never fails.
    function automatic logic entry_fails(input logic [REC_DATA_W-1:0] act,
                                         input logic [REC_DATA_W-1:0] expv,
                                         input logic [REC_DATA_W-1:0] msk);
        return |((act ^ expv) & msk);
    endfunction

endpackage

// File: rtl/instr_test_monitor_if.sv
// Bundle of all monitor-side signals except clock and reset.
// Failure stream: fail_valid qualifies fail_index/fail_expected/fail_actual
// for exactly one cycle; there is no ready, so the consumer must take every
// pulse in the cycle it is presented.
interface instr_test_monitor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int PC_WIDTH   = 20
);
    import instr_test_pkg::*;

    localparam int IW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic                  start;
    logic [PC_WIDTH-1:0]   pc;
    logic [IW-1:0]         reg_index;
    logic [DATA_WIDTH-1:0] reg_data;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [DATA_WIDTH-1:0] exp_mask;
    logic                  busy;
    logic                  done;
    logic                  passed;
    logic                  timed_out;
    logic [CW-1:0]         mismatch_count;
    logic [IW-1:0]         first_fail_index;
    logic                  fail_valid;
    logic [IW-1:0]         fail_index;
    logic [DATA_WIDTH-1:0] fail_expected;
    logic [DATA_WIDTH-1:0] fail_actual;
    state_t                dbg_state;

    modport slave (
        input  start, pc, reg_data, exp_data, exp_mask,
        output reg_index, busy, done, passed, timed_out, mismatch_count,
               first_fail_index, fail_valid, fail_index, fail_expected,
               fail_actual, dbg_state
    );

    modport master (
        output start, pc, reg_data, exp_data, exp_mask,
        input  reg_index, busy, done, passed, timed_out, mismatch_count,
               first_fail_index, fail_valid, fail_index, fail_expected,
               fail_actual, dbg_state
    );

endinterface

// File: rtl/instr_test_monitor_halt_detector.sv
// End-of-program detection: counts RUN cycles against the budget and counts
// consecutive cycles in which the fetch PC did not move.
module halt_detector #(
    parameter int TEST_LENGTH = 100,
    parameter int END_MODE    = 0,
    parameter int HALT_CYCLES = 8,
    parameter int PC_WIDTH    = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                run_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic                halt_hit_o,
    output logic                budget_hit_o
);
    import instr_test_pkg::*;

    localparam int BW = $clog2(TEST_LENGTH + 1);
    localparam int SW = $clog2(HALT_CYCLES + 1);

    logic [PC_WIDTH-1:0] pc_q;
    logic [BW-1:0]       cycle_q, cycle_d;
    logic [SW-1:0]       stable_q, stable_d;
    logic [SW-1:0]       stable_now;
    logic                pc_same;

    // stable_now includes this cycle's compare, so a PC held for HALT_CYCLES
    // cycles is recognised in the last of those cycles.
    assign pc_same      = (pc_i == pc_q);
    assign stable_now   = pc_same ? stable_q + SW'(1) : '0;
    assign halt_hit_o   = (END_MODE == END_HALT) && run_i
                          && (stable_now == SW'(HALT_CYCLES - 1));
    assign budget_hit_o = run_i && (cycle_q == BW'(TEST_LENGTH - 1));

    // Counters clear when a test is launched and advance only in RUN.
    always_comb begin
        cycle_d  = cycle_q;
        stable_d = stable_q;
        if (clear_i) begin
            cycle_d  = '0;
            stable_d = '0;
        end else if (run_i) begin
            cycle_d  = cycle_q + BW'(1);
            stable_d = stable_now;
        end
    end

    // PC history is sampled every cycle; counters take their next values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            cycle_q  <= '0;
            stable_q <= '0;
        end else begin
            pc_q     <= pc_i;
            cycle_q  <= cycle_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/instr_test_monitor.sv
// Post-run register-file checker: waits for the program to end, walks the
// register file against an expected/mask table and reports the outcome.
module instr_test_monitor #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int TEST_LENGTH = 100,
    parameter int END_MODE    = 0,
    parameter int HALT_CYCLES = 8,
    parameter int PC_WIDTH    = 20
) (
    input logic                 clock,
    input logic                 reset,
    instr_test_monitor_if.slave bus
);
    import instr_test_pkg::*;

    localparam int IW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    state_t          state_q;
    logic            busy_q, done_q, passed_q, timed_out_q, fail_valid_q;
    logic [IW-1:0]   idx_q, first_q;
    logic [CW-1:0]   count_q;
    fail_rec_t       rec_q, rec_d;
    logic            start_ok, run, halt_hit, budget_hit, entry_fail, last_idx;
    logic [REC_DATA_W-1:0] act_w, exp_w, msk_w;
    logic            unused_rec;

    assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);
    assign run      = (state_q == RUN);
    assign last_idx = (idx_q == IW'(NUM_REGS - 1));

    halt_detector #(
        .TEST_LENGTH (TEST_LENGTH),
        .END_MODE    (END_MODE),
        .HALT_CYCLES (HALT_CYCLES),
        .PC_WIDTH    (PC_WIDTH)
    ) u_halt (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (start_ok),
        .run_i        (run),
        .pc_i         (bus.pc),
        .halt_hit_o   (halt_hit),
        .budget_hit_o (budget_hit)
    );

    // Widen the compare operands and build the candidate failure record.
    always_comb begin
        act_w = '0;
        exp_w = '0;
        msk_w = '0;
        act_w[DATA_WIDTH-1:0] = bus.reg_data;
        exp_w[DATA_WIDTH-1:0] = bus.exp_data;
        msk_w[DATA_WIDTH-1:0] = bus.exp_mask;
        entry_fail = (state_q == SCAN) && entry_fails(act_w, exp_w, msk_w);
        rec_d = '0;
        rec_d.index[IW-1:0] = idx_q;
        rec_d.expected      = exp_w;
        rec_d.actual        = act_w;
    end

    // Control FSM with registered status outputs and failure record.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            passed_q     <= 1'b0;
            timed_out_q  <= 1'b0;
            fail_valid_q <= 1'b0;
            idx_q        <= '0;
            first_q      <= '0;
            count_q      <= '0;
            rec_q        <= '0;
        end else begin
            fail_valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        passed_q    <= 1'b0;
                        timed_out_q <= 1'b0;
                        count_q     <= '0;
                        first_q     <= '0;
                    end
                end
                RUN: begin
                    // Halt takes priority when both end conditions coincide.
                    if (halt_hit) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end else if (budget_hit) begin
                        state_q     <= SCAN;
                        idx_q       <= '0;
                        timed_out_q <= (END_MODE == END_HALT);
                    end
                end
                SCAN: begin
                    if (entry_fail) begin
                        fail_valid_q <= 1'b1;
                        rec_q        <= rec_d;
                        if (count_q == '0) first_q <= idx_q;
                        if (count_q != CW'(NUM_REGS)) count_q <= count_q + CW'(1);
                    end
                    if (last_idx) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        idx_q    <= '0;
                        passed_q <= (count_q == '0) && !entry_fail && !timed_out_q;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign unused_rec           = ^rec_q;
    assign bus.reg_index        = idx_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.passed           = passed_q;
    assign bus.timed_out        = timed_out_q;
    assign bus.mismatch_count   = count_q;
    assign bus.first_fail_index = first_q;
    assign bus.fail_valid       = fail_valid_q;
    assign bus.fail_index       = rec_q.index[IW-1:0];
    assign bus.fail_expected    = rec_q.expected[DATA_WIDTH-1:0];
    assign bus.fail_actual      = rec_q.actual[DATA_WIDTH-1:0];
    assign bus.dbg_state        = state_q;

endmodule

// File: doc/instr_test_monitor.md
# instr_test_monitor

Parametrised, synthesizable self-check engine for the per-instruction core tests. After a start pulse it waits for the program to finish, either after a fixed cycle budget or when the PC settles in a terminating `j .` loop. It then walks the core register file one entry per cycle against an expected-value/mask table. It reports pass/fail, a mismatch count, the first failing index, and a per-mismatch record stream for logging. It sits beside `RISC_V_Core` in test harnesses and FPGA bring-up tops, replacing hand-written end-of-test compare loops.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register and expected-value width
- `NUM_REGS`, 32, entries to check (index 0..NUM_REGS-1)
- `TEST_LENGTH`, 100, cycle budget in RUN; minimum 1
- `END_MODE`, 0, 0 = fixed length, 1 = halt detect with TEST_LENGTH as timeout
- `HALT_CYCLES`, 8, consecutive unchanged-PC cycles that define halt; minimum 2
- `PC_WIDTH`, 20, width of the observed PC

Ports (IW = $clog2(NUM_REGS), CW = $clog2(NUM_REGS+1)):
- `clock` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-high
- `start` in 1, single-cycle pulse; begins a test
- `pc` in PC_WIDTH, core fetch PC
- `reg_index` out IW, register-file and expected-table read index
- `reg_data` in DATA_WIDTH, combinational register-file read of `reg_index`
- `exp_data` in DATA_WIDTH, expected value at `reg_index`
- `exp_mask` in DATA_WIDTH, 1 = bit is compared
- `busy` out 1, high in RUN or SCAN
- `done` out 1, high in DONE
- `passed` out 1, valid while `done`
- `timed_out` out 1, END_MODE 1 only: the budget expired before halt
- `mismatch_count` out CW, number of failing entries
- `first_fail_index` out IW, lowest failing index; 0 if none
- `fail_valid` out 1, one-cycle pulse per failing entry
- `fail_index` out IW, index of the failing entry
- `fail_expected` out DATA_WIDTH, expected value of the failing entry
- `fail_actual` out DATA_WIDTH, actual value of the failing entry

## Operation
The block is an FSM with states IDLE, RUN, SCAN and DONE. Reset clears the state to IDLE, and every output and counter to 0.

- **IDLE / DONE:** `start` = 1 moves to RUN. On that transition the monitor clears the cycle counter, the stable counter, `mismatch_count`, `first_fail_index`, `timed_out` and `passed`.
- **RUN:** the cycle counter increments every cycle.
  - END_MODE 0: when the counter reaches TEST_LENGTH-1, the next state is SCAN.
  - END_MODE 1: the stable counter increments when `pc` equals its registered previous value, and clears otherwise.
  - Reaching HALT_CYCLES-1 moves to SCAN.
  - Otherwise, reaching the budget moves to SCAN and sets `timed_out`.
  - If halt and the budget hit in the same cycle, halt wins and `timed_out` stays 0.
- **SCAN:** `reg_index` = idx, where idx starts at 0 and increments each cycle.
  - An entry fails when `((reg_data ^ exp_data) & exp_mask) != 0`.
  - After idx = NUM_REGS-1 is compared, the next state is DONE.
- **DONE:** `passed` = (`mismatch_count` == 0) && !`timed_out`. The block stays in DONE until `start` or `reset`.
- `start` is ignored in RUN and SCAN.
- `mismatch_count` saturates at NUM_REGS; it cannot overflow by construction.
- `exp_mask` = 0 never fails.
- `reg_index` is 0 outside SCAN.

## Timing
- `start` is sampled at edge E. The monitor is in RUN from E+1 with `busy` = 1.
- In END_MODE 0, RUN lasts exactly TEST_LENGTH cycles.
- SCAN lasts NUM_REGS cycles.
- The fail record (`fail_*`) is registered and appears the cycle after its compare.
- `mismatch_count` and `first_fail_index` also update on the edge after the compare.
- `done` rises on the edge after the last compare, in the same cycle as the last possible `fail_valid`.
- Total latency in END_MODE 0: `done` at E+1+TEST_LENGTH+NUM_REGS.
- `reset` asserted in any state returns the block to IDLE asynchronously and clears all outputs. A scan in progress is discarded.

## Structure
- Shared package `instr_test_pkg` holds:
  - the state enum (IDLE/RUN/SCAN/DONE)
  - END_MODE constants (`END_FIXED` = 0, `END_HALT` = 1)
  - the fail-record struct {index, expected, actual}
- One natural sub-module: `halt_detector`. It contains the PC register, the stable counter and the budget counter, and outputs `halt_hit` and `budget_hit`.
- The top level holds the FSM, the scan index, the comparator and the counters.

## Test plan
- **Fixed length, all match:** END_MODE 0, TEST_LENGTH=100, expected[11]=0x00001004, expected[12]=0xfffff008, rest 0, core matches -> `done` at E+133, `passed`=1, `mismatch_count`=0, no `fail_valid`.
- **Single mismatch:** actual[12]=0xfffff000 -> one `fail_valid` with index 12, expected 0xfffff008, actual 0xfffff000. Result: `mismatch_count`=1, `first_fail_index`=12, `passed`=0.
- **Mask:** the same mismatch with `exp_mask[12]`=0xfffff000 -> `passed`=1. Entries 3 and 7 wrong with full mask -> count 2, `first_fail_index`=3.
- **Halt detect:** END_MODE 1, HALT_CYCLES=8, PC frozen from RUN cycle 20 -> SCAN entered after cycle 27, `timed_out`=0. PC never frozen -> `timed_out`=1 and `passed`=0 even when all registers match.
- **Reset and restart:** `reset` at SCAN idx 10 -> all outputs 0 immediately, IDLE. `start` pulsed during RUN is ignored. `start` in DONE reruns with cleared counters.
